// File: rtl/intersection_phase_arbiter.sv
// intersection_phase_arbiter: sequences a four-approach intersection through
// ALLRED -> GREEN -> YELLOW. Grants are chosen round-robin with minimum and
// maximum green limits. Approach 0 (the highway) is the rest grant.
// Optional feature macro: PREEMPT_EN compiles in the emergency-vehicle preempt.
// All outputs are registered from the next-state values.
module intersection_phase_arbiter #(
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned ALLRED_TICKS = 2,
    parameter int unsigned MIN_GREEN    = 4,
    parameter int unsigned MAX_GREEN    = 10,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       preempt_vld,
    input  logic [1:0] preempt_dir,
    output logic [7:0] light,
    output logic [1:0] grant,
    output logic [1:0] phase,
    output logic       preempt_ack
);

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] YEL_C = CNT_W'(YELLOW_TICKS);
    localparam logic [CNT_W-1:0] AR_C  = CNT_W'(ALLRED_TICKS);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_GREEN);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt, t_inc;
    logic [1:0]       grant_nxt, last, last_nxt;
    logic [1:0]       rr_sel, rr_idx, sel;
    logic             rr_hit, other, pre_act;
    logic [7:0]       light_nxt;
    logic [1:0]       phase_nxt;
    logic             ack_nxt;

`ifdef PREEMPT_EN
    assign pre_act = preempt_vld;
`else
    logic unused_preempt;
    assign pre_act        = 1'b0;
    assign unused_preempt = ^{preempt_vld, preempt_dir};
`endif

    // Timer value after this cycle's tick, saturating at the max-green limit.
    always_comb begin
        t_inc = timer;
        if (tick && (timer < MAX_C)) begin
            t_inc = timer + 1'b1;
        end
    end

    // Round-robin search from last+1 upward; last itself is checked last.
    always_comb begin
        rr_sel = 2'd0;
        rr_hit = 1'b0;
        rr_idx = 2'd0;
        for (int unsigned k = 1; k <= 4; k++) begin
            rr_idx = last + 2'(k);
            if (!rr_hit && req[rr_idx]) begin
                rr_sel = rr_idx;
                rr_hit = 1'b1;
            end
        end
    end

    assign sel   = pre_act ? preempt_dir : (rr_hit ? rr_sel : 2'd0);
    assign other = |(req & ~(4'b0001 << grant));

    // Next-state, timer, grant and registered-output values.
    always_comb begin
        state_nxt = state;
        timer_nxt = t_inc;
        grant_nxt = grant;
        last_nxt  = last;
        case (state)
            ALLRED: begin
                if (tick && (t_inc >= AR_C)) begin
                    state_nxt = GREEN;
                    timer_nxt = '0;
                    grant_nxt = sel;
                    last_nxt  = sel;
                end
            end
            GREEN: begin
                if (pre_act && (preempt_dir != grant)) begin
                    state_nxt = YELLOW;
                    timer_nxt = '0;
                end else if (!pre_act && tick && (t_inc >= MIN_C) && other &&
                             (!req[grant] || (t_inc >= MAX_C))) begin
                    state_nxt = YELLOW;
                    timer_nxt = '0;
                end
            end
            YELLOW: begin
                if (tick && (t_inc >= YEL_C)) begin
                    state_nxt = ALLRED;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = ALLRED;
                timer_nxt = '0;
            end
        endcase

        light_nxt = '0;
        if (state_nxt == GREEN) begin
            light_nxt = 8'h02 << {grant_nxt, 1'b0};
        end else if (state_nxt == YELLOW) begin
            light_nxt = 8'h01 << {grant_nxt, 1'b0};
        end
        phase_nxt = state_nxt;
        ack_nxt   = pre_act && (state_nxt == GREEN) && (grant_nxt == preempt_dir);
    end

    // State, timer, arbitration pointer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ALLRED;
            timer       <= '0;
            last        <= 2'd3;
            grant       <= 2'd0;
            light       <= '0;
            phase       <= 2'd0;
            preempt_ack <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            last        <= last_nxt;
            grant       <= grant_nxt;
            light       <= light_nxt;
            phase       <= phase_nxt;
            preempt_ack <= ack_nxt;
        end
    end

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Self-checking bench for intersection_phase_arbiter: directed scenarios plus
// randomized traffic, compared cycle by cycle against a tick-counting model.
module tb_intersection_phase_arbiter;

    localparam int YT   = 3;
    localparam int AT   = 2;
    localparam int MING = 4;
    localparam int MAXG = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] req;
    logic       preempt_vld;
    logic [1:0] preempt_dir;
    logic [7:0] light;
    logic [1:0] grant;
    logic [1:0] phase;
    logic       preempt_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0/1/2 = allred/green/yellow, plain tick count.
    int m_phase;
    int m_cnt;
    int m_grant;
    int m_last;
    bit m_ack;

    intersection_phase_arbiter #(
        .YELLOW_TICKS(YT),
        .ALLRED_TICKS(AT),
        .MIN_GREEN   (MING),
        .MAX_GREEN   (MAXG),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .req        (req),
        .preempt_vld(preempt_vld),
        .preempt_dir(preempt_dir),
        .light      (light),
        .grant      (grant),
        .phase      (phase),
        .preempt_ack(preempt_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_light();
        if (m_phase == 1) return 8'h02 << (2 * m_grant);
        if (m_phase == 2) return 8'h01 << (2 * m_grant);
        return 8'h00;
    endfunction

    task automatic m_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_grant = 0;
        m_last  = 3;
        m_ack   = 0;
    endtask

    task automatic m_step();
        bit pre;
        int nc;
        bit oth;
        int g;
`ifdef PREEMPT_EN
        pre = preempt_vld;
`else
        pre = 1'b0;
`endif
        nc  = tick ? m_cnt + 1 : m_cnt;
        oth = (req & ~(4'b0001 << m_grant)) != 4'b0000;
        case (m_phase)
            0: begin
                if (tick && nc >= AT) begin
                    g = 0;
                    if (pre) begin
                        g = int'(preempt_dir);
                    end else begin
                        for (int k = 1; k <= 4; k++) begin
                            if (req[(m_last + k) % 4]) begin
                                g = (m_last + k) % 4;
                                break;
                            end
                        end
                    end
                    m_grant = g;
                    m_last  = g;
                    m_phase = 1;
                    m_cnt   = 0;
                end else begin
                    m_cnt = nc;
                end
            end
            1: begin
                if (pre && int'(preempt_dir) != m_grant) begin
                    m_phase = 2;
                    m_cnt   = 0;
                end else if (!pre && tick && nc >= MING && oth &&
                             (!req[m_grant] || nc >= MAXG)) begin
                    m_phase = 2;
                    m_cnt   = 0;
                end else begin
                    m_cnt = nc;
                end
            end
            default: begin
                if (tick && nc >= YT) begin
                    m_phase = 0;
                    m_cnt   = 0;
                end else begin
                    m_cnt = nc;
                end
            end
        endcase
        m_ack = pre && (m_phase == 1) && (m_grant == int'(preempt_dir));
    endtask

    // One clock: drive on negedge, model on posedge, compare 1 time unit later.
    task automatic step(input bit tk, input logic [3:0] r, input bit pv, input logic [1:0] pd);
        @(negedge clk);
        tick        = tk;
        req         = r;
        preempt_vld = pv;
        preempt_dir = pd;
        @(posedge clk);
        m_step();
        #1;
        check("light", 32'(light), 32'(exp_light()));
        check("grant", 32'(grant), 32'(m_grant));
        check("phase", 32'(phase), 32'(m_phase));
        check("ack", 32'(preempt_ack), 32'(m_ack));
    endtask

    // Called 1 time unit after a posedge; asserts and releases reset between edges.
    task automatic do_reset();
        #1;
        reset = 1'b0;
        m_reset();
        #1;
        check("rst_light", 32'(light), 32'h00);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(preempt_ack), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         seen;
        int         vld_left;
        bit         pv;
        logic [1:0] pd;
        logic [3:0] r;

        reset       = 1'b0;
        tick        = 1'b0;
        req         = 4'b0000;
        preempt_vld = 1'b0;
        preempt_dir = 2'd0;
        m_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Idle after reset: two ticks of ALLRED, then rest on the highway.
        step(1'b1, 4'b0000, 1'b0, 2'd0);
        check("s1_allred", 32'(phase), 32'd0);
        step(1'b1, 4'b0000, 1'b0, 2'd0);
        check("s1_light", 32'(light), 32'h02);
        check("s1_grant", 32'(grant), 32'd0);
        repeat (20) step(1'b1, 4'b0000, 1'b0, 2'd0);
        check("s1_hold", 32'(light), 32'h02);

        // Side-road request on a fresh highway green yields at min green.
        do_reset();
        repeat (2) step(1'b1, 4'b0000, 1'b0, 2'd0);
        repeat (3) step(1'b1, 4'b0100, 1'b0, 2'd0);
        check("s2_green", 32'(phase), 32'd1);
        step(1'b1, 4'b0100, 1'b0, 2'd0);
        check("s2_yellow", 32'(light), 32'h01);
        repeat (2) step(1'b1, 4'b0100, 1'b0, 2'd0);
        check("s2_yellow_end", 32'(phase), 32'd2);
        step(1'b1, 4'b0100, 1'b0, 2'd0);
        check("s2_allred", 32'(light), 32'h00);
        step(1'b1, 4'b0100, 1'b0, 2'd0);
        check("s2_allred_end", 32'(phase), 32'd0);
        step(1'b1, 4'b0100, 1'b0, 2'd0);
        check("s2_grant", 32'(grant), 32'd2);
        check("s2_light", 32'(light), 32'h20);

        // All approaches requesting: max-green rotation 2 -> 3 -> 0 -> 1.
        for (int k = 0; k < 3; k++) begin
            repeat (9) step(1'b1, 4'b1111, 1'b0, 2'd0);
            check("s3_green", 32'(phase), 32'd1);
            step(1'b1, 4'b1111, 1'b0, 2'd0);
            check("s3_yellow", 32'(phase), 32'd2);
            repeat (5) step(1'b1, 4'b1111, 1'b0, 2'd0);
            check("s3_next_grant", 32'(grant), 32'((3 + k) % 4));
            check("s3_next_phase", 32'(phase), 32'd1);
        end

        // Preempt toward approach 3 while approach 1 holds green.
        step(1'b1, 4'b0111, 1'b0, 2'd3);
        step(1'b1, 4'b0111, 1'b1, 2'd3);
`ifdef PREEMPT_EN
        check("s4_abort", 32'(phase), 32'd2);
        check("s4_abort_grant", 32'(grant), 32'd1);
        repeat (3) step(1'b1, 4'b0111, 1'b1, 2'd3);
        check("s4_allred", 32'(phase), 32'd0);
        repeat (2) step(1'b1, 4'b0111, 1'b1, 2'd3);
        check("s4_grant", 32'(grant), 32'd3);
        check("s4_ack", 32'(preempt_ack), 32'd1);
        check("s4_light", 32'(light), 32'h80);
        repeat (15) step(1'b1, 4'b0111, 1'b1, 2'd3);
        check("s4_hold_grant", 32'(grant), 32'd3);
        check("s4_hold_phase", 32'(phase), 32'd1);
        check("s4_hold_ack", 32'(preempt_ack), 32'd1);
`else
        check("s4_noabort", 32'(phase), 32'd1);
        check("s4_noack", 32'(preempt_ack), 32'd0);
        repeat (15) step(1'b1, 4'b0111, 1'b1, 2'd3);
        check("s4_rr_grant", 32'(grant), 32'd2);
        check("s4_rr_phase", 32'(phase), 32'd1);
        check("s4_rr_ack", 32'(preempt_ack), 32'd0);
`endif

        // Asynchronous reset in the middle of YELLOW.
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step(1'b1, 4'b1010, 1'b0, 2'd0);
            if (m_phase == 2) seen = 1'b1;
        end
        check("s6_reach_yellow", 32'(seen), 32'd1);
        do_reset();
        step(1'b1, 4'b0000, 1'b0, 2'd0);
        check("s6_allred", 32'(phase), 32'd0);
        step(1'b1, 4'b0000, 1'b0, 2'd0);
        check("s6_light", 32'(light), 32'h02);

        // Randomized traffic, ticks, preempt episodes and occasional resets.
        vld_left = 0;
        pv       = 1'b0;
        pd       = 2'd0;
        r        = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            if (vld_left > 0) begin
                pv = 1'b1;
                vld_left--;
            end else begin
                pv = 1'b0;
                if ($urandom_range(0, 24) == 0) begin
                    pd       = 2'($urandom_range(0, 3));
                    vld_left = $urandom_range(1, 30);
                end
            end
            if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, r, pv, pd);
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/intersection_phase_arbiter.md
# intersection_phase_arbiter

- Sequences a four-approach intersection (approach 0 = highway, 1..3 = side roads) through green, yellow and all-red phases.
- Arbitrates the shared intersection among the approach sensors using round-robin with minimum- and maximum-green limits.
- Supports an optional emergency-vehicle preempt.
- Sits above the per-approach lamp drivers, consuming a 1-second `tick` strobe from the system timebase.

## Interface
- `YELLOW_TICKS`, 3: ticks spent in YELLOW.
- `ALLRED_TICKS`, 2: ticks spent in ALLRED.
- `MIN_GREEN`, 4: minimum green ticks before yielding to another request (≥1).
- `MAX_GREEN`, 10: green ticks after which a still-requesting holder must yield (≥ `MIN_GREEN`, < 2^`CNT_W`).
- `CNT_W`, 4: phase timer width.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  single-cycle timebase strobe; timers advance only when high.
- `req`  in  4  per-approach vehicle-present sensors; level-sensitive, bit i = approach i.
- `preempt_vld`  in  1  emergency preempt request; level, held until serviced.
- `preempt_dir`  in  2  approach the emergency vehicle needs; stable while `preempt_vld`=1.
- `light`  out  8  lamp code per approach, bits [2i+1:2i]; RED=0, YELLOW=1, GREEN=2.
- `grant`  out  2  approach currently owning green/yellow.
- `phase`  out  2  ALLRED=0, GREEN=1, YELLOW=2.
- `preempt_ack`  out  1  high while GREEN, `preempt_vld`=1 and `grant`==`preempt_dir`.

## Operation
- FSM states: ALLRED, GREEN, YELLOW. Phase timer is cleared on every state entry.
- On each `tick`, the timer increments, saturating at `MAX_GREEN`.
- ALLRED:
  - All lamps RED.
  - On the tick that completes `ALLRED_TICKS`, select the next grant and enter GREEN.
- Grant selection, in priority order:
  - Preempt active: `preempt_dir`.
  - Otherwise, round-robin: first approach with `req` set, searching from `last`+1 mod 4 upward.
  - Otherwise, approach 0 (rest on highway).
  - Selection updates `last`.
- GREEN:
  - `light` shows GREEN for `grant`, RED elsewhere.
  - Let `t` = timer value after the current tick's increment and `other` = any `req` bit set except `grant`.
  - On a tick, go to YELLOW if `t` ≥ `MIN_GREEN` and `other`, and either `req[grant]`=0 or `t` ≥ `MAX_GREEN`.
  - With `other`=0, green holds indefinitely.
- YELLOW:
  - `light` shows YELLOW for `grant`, RED elsewhere.
  - On the tick that completes `YELLOW_TICKS`, go to ALLRED.
- Preempt, active when `preempt_vld`=1:
  - In GREEN with `preempt_dir` ≠ `grant`: go to YELLOW on the next clock edge regardless of `tick` or `MIN_GREEN`.
  - In GREEN with `preempt_dir` == `grant`: hold green; max-green yield is suppressed.
  - In YELLOW/ALLRED: sequence completes normally; the next selection grants `preempt_dir`.
  - Preempt does not advance `last` beyond the granted approach.
- Never more than one approach is non-RED; every grant change passes YELLOW then ALLRED.

## Timing
- Reset (asynchronous, any state, mid-phase included) forces:
  - state ALLRED, timer 0, `last`=3
  - `light`=8'h00, `grant`=0, `phase`=0, `preempt_ack`=0
- After reset deassertion, first GREEN appears after `ALLRED_TICKS` ticks.
- All outputs are registered. They change on the clock edge where the transition is evaluated and are visible the following cycle.
- Preempt abort latency: `preempt_vld` high in cycle N during GREEN → `phase`=YELLOW from cycle N+1.
- A tick coincident with the preempt abort is consumed by the abort; YELLOW still lasts a full `YELLOW_TICKS`.
- `req` changes between ticks are sampled only at evaluating ticks. `preempt_vld` is sampled every cycle.
- Durations are in ticks; with `tick` tied high they equal clock cycles.

## Configuration
- `PREEMPT_EN` defined:
  - Preempt logic compiled in as described.
- `PREEMPT_EN` undefined:
  - `preempt_vld`/`preempt_dir` ports remain but are ignored.
  - `preempt_ack` is tied 0.
  - Arbitration is pure round-robin with min/max green.

## Test plan
All scenarios use default parameters with `tick` tied high.

- Reset then `req`=4'b0000 → ALLRED for 2 cycles, then `grant`=0, `light`=8'h02, held indefinitely.
- `grant`=0 green, `req`=4'b0100 asserted at green cycle 0 with `req[0]`=0:
  - YELLOW after 4 cycles (`light`=8'h01) for 3 cycles, then ALLRED (`light`=8'h00) for 2 cycles.
  - Then `grant`=2, `light`=8'h20.
- `req`=4'b1111 continuously → grants cycle 0→1→2→3→0, each green exactly 10 ticks.
- `PREEMPT_EN`, GREEN on 1 at cycle 1, `preempt_vld`=1 with `preempt_dir`=3:
  - YELLOW on 1 next cycle, then ALLRED.
  - Then `grant`=3 with `preempt_ack`=1, held past 10 ticks despite `req`=4'b0111.
- Assert `reset`=0 mid-YELLOW → same cycle `light`=8'h00, `phase`=0; restart as in first scenario.
- Without `PREEMPT_EN`, repeat the preempt scenario → no abort, `preempt_ack` stays 0, normal round-robin.
